// File: rtl/sync_mod_updown_counter_if.sv
// Bundle of control inputs and status outputs for the modulo up/down counter.
// master drives the controls and observes the count; slave is the counter itself.
interface sync_mod_updown_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             y;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, din,
        input  q, y, tc, wrap
    );

    modport slave (
        input  en, up, load, din,
        output q, y, tc, wrap
    );
endinterface

// File: rtl/sync_mod_updown_counter.sv
// Parametrised synchronous modulo-MODULUS up/down counter with parallel load,
// two decoded match values (y), terminal count (tc) and a registered wrap pulse.
// The only state is the count and the wrap flag; everything else is decode.
module sync_mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int MATCH_A = 3,
    parameter int MATCH_B = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    sync_mod_updown_counter_if.slave   bus
);

    // Top of the count range. MODULUS may be 2**WIDTH, so the limit is kept as
    // MODULUS-1 (always representable) and load range checks use one extra bit.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MATCH_A_V = WIDTH'(MATCH_A);
    localparam logic [WIDTH-1:0] MATCH_B_V = WIDTH'(MATCH_B);
    localparam logic [WIDTH-1:0] ZERO_V  = '0;
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             din_in_range;
    logic             at_max;
    logic             at_zero;

    assign din_in_range = ({1'b0, bus.din} < MOD_EXT);
    assign at_max       = (q_r == MAX_VAL);
    assign at_zero      = (q_r == ZERO_V);

    // Next-state selection: load beats count enable, which beats hold.
    // Boundary values are compared explicitly rather than relying on binary
    // overflow so the range holds for any modulus, including 2**WIDTH.
    always_comb begin
        q_next    = q_r;
        wrap_next = 1'b0;
        if (bus.load) begin
            q_next = din_in_range ? bus.din : ZERO_V;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    q_next    = ZERO_V;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_r + ONE_V;
                end
            end else begin
                if (at_zero) begin
                    q_next    = MAX_VAL;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_r - ONE_V;
                end
            end
        end
    end

    // Count and wrap registers; reset clears both immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            wrap_r <= wrap_next;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;

    // Zero-latency decodes of the current count and inputs.
    assign bus.y  = (q_r == MATCH_A_V) || (q_r == MATCH_B_V);
    assign bus.tc = bus.en & ~bus.load & ((bus.up & at_max) | (~bus.up & at_zero));

endmodule

// File: tb/tb_sync_mod_updown_counter.sv
// Directed bench: a default counter (WIDTH=4, MODULUS=10) and a full-range
// counter (WIDTH=4, MODULUS=16), both checked against hand-computed counts.
module tb_sync_mod_updown_counter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sync_mod_updown_counter_if #(.WIDTH(4)) ifa ();
    sync_mod_updown_counter_if #(.WIDTH(4)) ifb ();

    sync_mod_updown_counter #(
        .WIDTH(4), .MODULUS(10), .MATCH_A(3), .MATCH_B(9)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );

    sync_mod_updown_counter #(
        .WIDTH(4), .MODULUS(16), .MATCH_A(3), .MATCH_B(9)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks all four outputs of one counter; y and tc expectations come from
    // the expected count, the current inputs and the counter's parameters.
    task automatic chk_all(input string tag, input int modulus,
                           input logic [3:0] q, input logic wrap, input logic y, input logic tc,
                           input logic en, input logic up, input logic load,
                           input int exp_q, input bit exp_wrap);
        logic exp_y;
        logic exp_tc;
        exp_y  = (exp_q == 3) || (exp_q == 9);
        exp_tc = en & ~load & ((up & (exp_q == modulus - 1)) | (~up & (exp_q == 0)));
        chk({tag, ".q"},    32'(q),    32'(exp_q));
        chk({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        chk({tag, ".y"},    32'(y),    32'(exp_y));
        chk({tag, ".tc"},   32'(tc),   32'(exp_tc));
    endtask

    task automatic chk_a(input string tag, input int exp_q, input bit exp_wrap);
        chk_all({"a.", tag}, 10, ifa.q, ifa.wrap, ifa.y, ifa.tc,
                ifa.en, ifa.up, ifa.load, exp_q, exp_wrap);
    endtask

    task automatic chk_b(input string tag, input int exp_q, input bit exp_wrap);
        chk_all({"b.", tag}, 16, ifb.q, ifb.wrap, ifb.y, ifb.tc,
                ifb.en, ifb.up, ifb.load, exp_q, exp_wrap);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int up_seq_a [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifa.en = 1'b0; ifa.up = 1'b1; ifa.load = 1'b0; ifa.din = 4'd0;
        ifb.en = 1'b0; ifb.up = 1'b1; ifb.load = 1'b0; ifb.din = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_a("reset", 0, 1'b0);
        chk_b("reset", 0, 1'b0);
        reset = 1'b0;

        // Up count with wrap through 9 -> 0
        ifa.en = 1'b1; ifa.up = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk_a($sformatf("up%0d", i), up_seq_a[i], up_seq_a[i] == 0);
        end

        // Down count: 1 -> 0 (tc high at 0), then wrap to 9, then 8, 7
        ifa.up = 1'b0;
        tick(); chk_a("dn0", 0, 1'b0);
        tick(); chk_a("dnwrap", 9, 1'b1);
        tick(); chk_a("dn8", 8, 1'b0);
        tick(); chk_a("dn7", 7, 1'b0);

        // Load priority and range check
        ifa.load = 1'b1; ifa.din = 4'd5;
        tick(); chk_a("ld5", 5, 1'b0);
        ifa.en = 1'b1; ifa.up = 1'b0; ifa.din = 4'd7;
        tick(); chk_a("ld7", 7, 1'b0);
        ifa.up = 1'b1; ifa.din = 4'd9;
        tick(); chk_a("ld9_tcmask", 9, 1'b0);
        ifa.din = 4'd12;
        tick(); chk_a("ld12", 0, 1'b0);
        ifa.din = 4'd10;
        tick(); chk_a("ld10", 0, 1'b0);
        ifa.din = 4'd4;
        tick(); chk_a("ld4", 4, 1'b0);

        // Hold for three edges, then direction flips with no dead cycle
        ifa.load = 1'b0; ifa.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("hold%0d", i), 4, 1'b0);
        end
        ifa.en = 1'b1; ifa.up = 1'b1;
        tick(); chk_a("flip_up", 5, 1'b0);
        ifa.up = 1'b0;
        tick(); chk_a("flip_dn", 4, 1'b0);
        ifa.up = 1'b1;
        tick(); chk_a("flip_up2", 5, 1'b0);

        // Wrap pulse is cleared by a hold edge and by a load edge
        ifa.load = 1'b1; ifa.din = 4'd9;
        tick(); chk_a("pre_wrap", 9, 1'b0);
        ifa.load = 1'b0; ifa.en = 1'b1; ifa.up = 1'b1;
        tick(); chk_a("wrap_up", 0, 1'b1);
        ifa.en = 1'b0;
        tick(); chk_a("wrap_hold_clr", 0, 1'b0);
        ifa.en = 1'b1; ifa.up = 1'b0;
        tick(); chk_a("wrap_dn", 9, 1'b1);
        ifa.load = 1'b1; ifa.din = 4'd2;
        tick(); chk_a("wrap_load_clr", 2, 1'b0);

        // Async reset mid-cycle at q=6, then resume from 0
        ifa.din = 4'd6;
        tick(); chk_a("ld6", 6, 1'b0);
        ifa.load = 1'b0; ifa.en = 1'b1; ifa.up = 1'b1;
        #4;
        reset = 1'b1;
        #1;
        chk_a("async_rst", 0, 1'b0);
        #1;
        reset = 1'b0;
        tick(); chk_a("post_rst", 1, 1'b0);
        ifa.en = 1'b0;

        // Full-range modulus: natural binary wrap at 15 -> 0
        ifb.en = 1'b1; ifb.up = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk_b($sformatf("up%0d", i), (i + 1) % 16, ((i + 1) % 16) == 0);
        end
        ifb.up = 1'b0;
        tick(); chk_b("dn0", 0, 1'b0);
        tick(); chk_b("dnwrap", 15, 1'b1);

        // Async reset while the wrap pulse is high
        #4;
        reset = 1'b1;
        #1;
        chk_b("async_rst_wrap", 0, 1'b0);
        #1;
        reset = 1'b0;
        ifb.load = 1'b1; ifb.din = 4'd15;
        tick(); chk_b("ld15", 15, 1'b0);
        ifb.load = 1'b0; ifb.up = 1'b1;
        tick(); chk_b("wrap15", 0, 1'b1);
        tick(); chk_b("after_wrap", 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_mod_updown_counter.md
Name: sync_mod_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter; successor to the fixed 4-bit T-style up counter with hard-wired state decode.
- Adds configurable width and modulus, count enable, direction control, parallel load, two parameter-selected match values, terminal-count and wrap outputs.
- Used as a general sequencing/timing counter in counter-based datapaths and as a test target for the counter exercise set.

Parameters:
- WIDTH, 4, counter bit width; legal range 2..16.
- MODULUS, 10, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- MATCH_A, 3, first decoded value for y; must be < MODULUS.
- MATCH_B, 9, second decoded value for y; must be < MODULUS; may equal MATCH_A.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- y  output  1  high when q == MATCH_A or q == MATCH_B; combinational decode of q.
- tc  output  1  terminal count; combinational: en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a counting wrap.

Behaviour:
- Reset: when reset is high, q = 0 and wrap = 0 immediately, independent of clk. y reflects q = 0, so y = 1 only if a match parameter is 0. tc follows its equation.
- Priority at each rising clk edge with reset low:
  - load > en > hold.
- load = 1:
  - q <= din if din < MODULUS, else q <= 0.
  - wrap <= 0.
  - en and up are ignored.
- load = 0, en = 1, up = 1:
  - q <= q+1 if q < MODULUS-1.
  - Else q <= 0 and wrap <= 1.
- load = 0, en = 1, up = 0:
  - q <= q-1 if q > 0.
  - Else q <= MODULUS-1 and wrap <= 1.
- load = 0, en = 0: q holds; wrap <= 0.
- wrap is high for exactly one cycle per wrap. Continuous counting at the boundary gives isolated pulses every MODULUS cycles.
- Latency:
  - q changes one clk edge after the controlling inputs are sampled.
  - y and tc have zero latency relative to q/inputs.
  - wrap is coincident with the post-wrap q value.
- Direction change: up is sampled every edge. Toggling up mid-count reverses on the next edge with no dead cycle.
- Out-of-range state: q never leaves 0..MODULUS-1 under any input sequence. This includes MODULUS = 2**WIDTH, where the natural binary wrap must give the same result.
- Reset mid-operation: asserting reset between edges clears q/wrap asynchronously. The first edge after deassertion acts on the inputs normally from q = 0.
- Arithmetic is unsigned, modulo MODULUS. No internal state beyond q and wrap.

Test Plan:
- Reset then up-count: reset pulse, en=1, up=1, load=0, defaults (WIDTH=4, MODULUS=10) for 11 edges -> q sequence 1,2,...,9,0,1. y high only at q=3 and q=9. tc high while q=9. wrap high only in the cycle q returns to 0.
- Down wrap: from q=0, en=1, up=0 -> q=9, wrap=1 for one cycle. Next edges give 8,7. tc high while q=0.
- Load priority and range: q=5, load=1, en=1, din=7 -> q=7, wrap=0. Then load=1, din=12 -> q=0.
- Hold and direction flip: en=0 for 3 edges at q=4 -> q stays 4, wrap=0. Then en=1, up toggling 1,0,1 -> q 5,4,5.
- Full-range modulus: WIDTH=4, MODULUS=16, up for 17 edges -> q 1..15,0,1. Single wrap pulse when q returns to 0. tc at q=15.
- Async reset mid-count: assert reset halfway between edges at q=6 -> q=0 and wrap=0 before the next edge. Release reset, en=1, up=1 -> next edge q=1.
